// File: rtl/udp_csum_pkg.sv
// udp_csum_pkg: protocol constants, beat-0 byte offsets, word masks and state type
package udp_csum_pkg;
  localparam logic [15:0] TYPE_IP = 16'h0800;
  localparam logic [7:0] PROTOCOL_UDP = 8'd17;
  localparam int ETH_TYPE = 12;
  localparam int IP_PROTO = 23;
  localparam int IP_SRC = 26;
  localparam int IP_DST = 30;
  localparam int UDP_LEN = 38;
  localparam int UDP_CSUM = 40;
  localparam int IP_CSUM = 24;
  // beat-0 words: IP addresses, UDP header and payload, skipping the UDP checksum word
  localparam logic [31:0] UDP_MASK = 32'hFFEF_E000;
  // IPv4 header words 7..16, skipping the header checksum word
  localparam logic [31:0] IP_MASK = 32'h0001_EF80;
  typedef enum logic [1:0] {IN, FOLD, OUT} state_t;
  function automatic logic [7:0] byte_at(input logic [511:0] d, input int k);
    return d[8*k +: 8];
  endfunction
  function automatic logic [15:0] fold16(input logic [31:0] s);
    logic [16:0] a;
    a = {1'b0, s[31:16]} + {1'b0, s[15:0]};
    return a[15:0] + {15'd0, a[16]};
  endfunction
endpackage

// File: rtl/csum_beat_adder.sv
// csum_beat_adder: masked sum of the 32 big-endian 16-bit words of a beat, unkept bytes read as zero
module csum_beat_adder (
  input  logic [511:0] data,
  input  logic [63:0]  keep,
  input  logic [31:0]  mask,
  output logic [20:0]  sum
);
  always_comb begin
    sum = '0;
    for (int j = 0; j < 32; j++)
      sum = sum + (mask[j] ? {5'd0, keep[2*j] ? data[16*j +: 8] : 8'h00, keep[2*j+1] ? data[16*j+8 +: 8] : 8'h00} : 21'd0);
  end
endmodule

// File: rtl/udp_checksum_inserter.sv
// udp_checksum_inserter: store-and-forward UDP checksum insertion; UDP_CSUM_IP_HDR_EN also rewrites the IPv4 header checksum
module udp_checksum_inserter
  import udp_csum_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int AXIS_TUSER_WIDTH = 256,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                         axis_aclk,
  input  logic                         axis_resetn,
  input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [AXIS_TUSER_WIDTH-1:0]  s_axis_tuser,
  input  logic                         s_axis_tvalid,
  input  logic                         s_axis_tlast,
  output logic                         s_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [AXIS_TUSER_WIDTH-1:0]  m_axis_tuser,
  output logic                         m_axis_tvalid,
  output logic                         m_axis_tlast,
  input  logic                         m_axis_tready,
  output logic [15:0]                  drop_count
);
  localparam int KW = AXIS_DATA_WIDTH / 8;
  localparam int EW = 1 + AXIS_TUSER_WIDTH + KW + AXIS_DATA_WIDTH;
  state_t state, state_nx;
  logic [EW-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [31:0] acc, pseudo;
  logic [20:0] beat_sum, ip_beat_sum, ip_acc;
  logic [15:0] udp_fold, udp_csum, ip_csum;
  logic [AXIS_DATA_WIDTH-1:0] beat0;
  logic is_udp, ihl5, dropping, in_hs, out_hs, first, full, beat0_udp, store;
  assign s_axis_tready = state == IN;
  assign in_hs = s_axis_tvalid && s_axis_tready;
  assign out_hs = m_axis_tvalid && m_axis_tready;
  assign first = wr_ptr == '0;
  assign full = wr_ptr[ADDR_WIDTH];
  assign store = in_hs && !dropping && !full;
  assign beat0_udp = {byte_at(s_axis_tdata, ETH_TYPE), byte_at(s_axis_tdata, ETH_TYPE + 1)} == TYPE_IP &&
                     byte_at(s_axis_tdata, IP_PROTO) == PROTOCOL_UDP;
  // pseudo-header terms not already covered by the beat-0 word mask
  assign pseudo = first ? {24'd0, byte_at(s_axis_tdata, IP_PROTO)} +
                          {16'd0, byte_at(s_axis_tdata, UDP_LEN), byte_at(s_axis_tdata, UDP_LEN + 1)} : 32'd0;
  csum_beat_adder u_udp (
    .data(s_axis_tdata), .keep(s_axis_tkeep), .mask(first ? UDP_MASK : 32'hFFFF_FFFF), .sum(beat_sum)
  );
`ifdef UDP_CSUM_IP_HDR_EN
  localparam bit IP_EN = 1'b1;
  csum_beat_adder u_ip (.data(s_axis_tdata), .keep(s_axis_tkeep), .mask(IP_MASK), .sum(ip_beat_sum));
`else
  localparam bit IP_EN = 1'b0;
  assign ip_beat_sum = '0;
`endif
  assign udp_fold = fold16(acc);
  assign udp_csum = &udp_fold ? 16'hFFFF : ~udp_fold;
  assign ip_csum = ~fold16({11'd0, ip_acc});
  always_comb begin
    beat0 = mem[0][AXIS_DATA_WIDTH-1:0];
    if (is_udp) beat0[8*UDP_CSUM +: 16] = {udp_csum[7:0], udp_csum[15:8]};
    if (IP_EN && is_udp && ihl5) beat0[8*IP_CSUM +: 16] = {ip_csum[7:0], ip_csum[15:8]};
  end
  always_comb begin
    state_nx = (state == IN && store && s_axis_tlast) ? FOLD :
               (state == FOLD) ? OUT :
               (state == OUT && out_hs && m_axis_tlast) ? IN : state;
  end
  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn) state <= IN;
    else state <= state_nx;
  end
  always_ff @(posedge axis_aclk) begin
    if (store) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};
  end
  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      acc <= '0;
      ip_acc <= '0;
      is_udp <= 1'b0;
      ihl5 <= 1'b0;
      dropping <= 1'b0;
      drop_count <= '0;
      m_axis_tdata <= '0;
      m_axis_tkeep <= '0;
      m_axis_tuser <= '0;
      m_axis_tlast <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else begin
      if (in_hs && !store) begin
        // oversize: swallow up to tlast, then count the drop
        dropping <= !s_axis_tlast;
        if (s_axis_tlast) begin
          wr_ptr <= '0;
          acc <= '0;
          if (~&drop_count) drop_count <= drop_count + 16'd1;
        end
      end else if (store) begin
        wr_ptr <= wr_ptr + 1'b1;
        acc <= acc + {11'd0, beat_sum} + pseudo;
        if (first) begin
          is_udp <= beat0_udp;
          ihl5 <= s_axis_tdata[8*14 +: 4] == 4'd5;
          ip_acc <= ip_beat_sum;
        end
      end
      if (state == FOLD) begin
        {m_axis_tlast, m_axis_tuser, m_axis_tkeep} <= mem[0][EW-1:AXIS_DATA_WIDTH];
        m_axis_tdata <= beat0;
        m_axis_tvalid <= 1'b1;
        rd_ptr <= ADDR_WIDTH'(1);
      end else if (out_hs) begin
        if (m_axis_tlast) begin
          m_axis_tvalid <= 1'b0;
          wr_ptr <= '0;
          rd_ptr <= '0;
          acc <= '0;
        end else begin
          {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata} <= mem[rd_ptr];
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_udp_checksum_inserter.sv
// tb_udp_checksum_inserter: directed frames checked against a byte-level checksum model and per-cycle output compare
module tb_udp_checksum_inserter;
  logic clk = 1'b0, resetn = 1'b0;
  logic [511:0] s_tdata = '0;
  logic [63:0] s_tkeep = '0;
  logic [255:0] s_tuser = '0;
  logic s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic [511:0] m_tdata;
  logic [63:0] m_tkeep;
  logic [255:0] m_tuser;
  logic m_tvalid, m_tlast, m_tready = 1'b1;
  logic [15:0] drop_count;
  always #5 clk = ~clk;
  udp_checksum_inserter dut (
    .axis_aclk(clk), .axis_resetn(resetn),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .drop_count(drop_count)
  );
  int checks = 0, errors = 0, cyc = 0, t_hs = -100, u_hs = -100;
  logic [7:0] pkt [0:4159];
  logic [255:0] usr [0:64];
  int plen;
  logic [832:0] exp_q [$];
  logic [832:0] e, prev_beat;
  logic prev_v = 1'b0, stalled = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask
  function automatic logic [15:0] oc(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction
  function automatic logic [15:0] w(input int i);
    return {pkt[i], (i + 1 < plen) ? pkt[i+1] : 8'h00};
  endfunction
  // RFC 768 checksum over pseudo-header and the UDP segment as it sits in the frame
  function automatic logic [15:0] model_udp();
    logic [15:0] s;
    s = 16'h0;
    for (int i = 26; i < 34; i += 2) s = oc(s, w(i));
    s = oc(s, {8'h00, pkt[23]});
    s = oc(s, w(38));
    for (int i = 34; i < plen; i += 2) if (i != 40) s = oc(s, w(i));
    return (~s == 16'h0) ? 16'hFFFF : ~s;
  endfunction
  function automatic logic [15:0] model_ip();
    logic [15:0] s;
    s = 16'h0;
    for (int i = 14; i < 34; i += 2) if (i != 24) s = oc(s, w(i));
    return ~s;
  endfunction
  task automatic mk_frame(input int len, input logic [15:0] et, input logic [7:0] pr);
    plen = len;
    for (int i = 0; i < 4160; i++) pkt[i] = 8'($urandom);
    for (int b = 0; b < 65; b++) for (int j = 0; j < 8; j++) usr[b][32*j +: 32] = $urandom;
    {pkt[12], pkt[13]} = et;
    if (et == 16'h0800) begin
      pkt[14] = 8'h45; pkt[15] = 8'h00;
      {pkt[16], pkt[17]} = 16'(len - 14);
      {pkt[18], pkt[19], pkt[20], pkt[21]} = 32'h0;
      pkt[22] = 8'd64; pkt[23] = pr;
      {pkt[26], pkt[27], pkt[28], pkt[29]} = 32'h0A00_0001;
      {pkt[30], pkt[31], pkt[32], pkt[33]} = 32'h0A00_0002;
      if (pr == 8'd17) begin
        {pkt[34], pkt[35]} = 16'd5000;
        {pkt[36], pkt[37]} = 16'd7;
        {pkt[38], pkt[39]} = 16'(len - 34);
        {pkt[40], pkt[41]} = 16'h0000;
      end
    end
  endtask
  task automatic expect_pkt();
    int nb;
    logic udp;
    logic [15:0] c, ic;
    logic [511:0] d;
    logic [63:0] k;
    nb = (plen + 63) / 64;
    udp = {pkt[12], pkt[13]} == 16'h0800 && pkt[23] == 8'd17;
    c = model_udp();
    ic = model_ip();
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < 64; i++) begin
        d[8*i +: 8] = pkt[64*b + i];
        k[i] = (64*b + i) < plen;
      end
      if (b == 0 && udp) begin
        d[8*40 +: 8] = c[15:8];
        d[8*41 +: 8] = c[7:0];
`ifdef UDP_CSUM_IP_HDR_EN
        if (pkt[14][3:0] == 4'd5) begin
          d[8*24 +: 8] = ic[15:8];
          d[8*25 +: 8] = ic[7:0];
        end
`endif
      end
      exp_q.push_back({b == nb - 1, usr[b], k, d});
    end
  endtask
  task automatic send(input int nsend);
    int nb, n;
    nb = (plen + 63) / 64;
    for (int b = 0; b < nsend; b++) begin
      for (int i = 0; i < 64; i++) begin
        s_tdata[8*i +: 8] = pkt[64*b + i];
        s_tkeep[i] = (64*b + i) < plen;
      end
      s_tuser = usr[b];
      s_tlast = b == nb - 1;
      s_tvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!s_tready && n < 300) begin @(negedge clk); n++; end
      if (!s_tready) begin
        checks++; errors++;
        $display("FAIL send_ready_timeout beat %0d", b);
      end
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 400) begin @(posedge clk); n++; end
    chk("drain_remaining", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!resetn) begin
      prev_v = 1'b0;
      stalled = 1'b0;
    end else begin
      if (s_tvalid && s_tready && s_tlast) t_hs = cyc;
      if (cyc == u_hs + 1) chk("ready_after_last", 64'(s_tready), 64'd1);
      if (m_tvalid && !prev_v) chk("first_beat_latency", 64'(cyc - t_hs), 64'd2);
      if (stalled) chk("stall_hold", 64'({m_tvalid, m_tlast, m_tuser, m_tkeep, m_tdata} !== {1'b1, prev_beat}), 64'd0);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat got %h", m_tdata[511:256]);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (m_tdata !== e[511:0]) begin
            errors++;
            $display("FAIL beat_data got %h want %h", m_tdata, e[511:0]);
          end
          checks++;
          if ({m_tlast, m_tuser, m_tkeep} !== e[832:512]) begin
            errors++;
            $display("FAIL beat_side got %h want %h", {m_tlast, m_tuser, m_tkeep}, e[832:512]);
          end
        end
        if (m_tlast) u_hs = cyc;
      end
      stalled = m_tvalid && !m_tready;
      prev_beat = {m_tlast, m_tuser, m_tkeep, m_tdata};
      prev_v = m_tvalid;
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_tready", 64'(s_tready), 64'd1);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tdata_hi", m_tdata[511:448], 64'd0);
    chk("rst_m_tkeep", m_tkeep, 64'd0);
    chk("rst_m_tlast", 64'(m_tlast), 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    mk_frame(46, 16'h0800, 8'd17);
    {pkt[42], pkt[43], pkt[44], pkt[45]} = 32'h4142_4344;
    chk("model_csum_abcd", 64'(model_udp()), 64'h53BE);
    expect_pkt();
    send(1);
    drain();
    mk_frame(149, 16'h0800, 8'd17);
    expect_pkt();
    send(3);
    for (int n = 0; n < 20 && !m_tvalid; n++) begin @(posedge clk); #1; end
    chk("stall_valid_seen", 64'(m_tvalid), 64'd1);
    @(posedge clk); #1; m_tready = 1'b0;
    @(posedge clk); #1; m_tready = 1'b0;
    @(posedge clk); #1; m_tready = 1'b1;
    drain();
    mk_frame(44, 16'h0800, 8'd17);
    {pkt[42], pkt[43]} = 16'hD848;
    chk("model_csum_zero", 64'(model_udp()), 64'hFFFF);
    expect_pkt();
    send(1);
    drain();
    mk_frame(100, 16'h0806, 8'd0);
    expect_pkt();
    send(2);
    drain();
    mk_frame(60, 16'h0800, 8'd6);
    expect_pkt();
    send(1);
    drain();
    mk_frame(4096, 16'h0800, 8'd17);
    expect_pkt();
    send(64);
    drain();
    chk("full_pkt_no_drop", 64'(drop_count), 64'd0);
    mk_frame(4100, 16'h0800, 8'd17);
    send(65);
    repeat (10) @(posedge clk);
    #1;
    chk("drop_count_one", 64'(drop_count), 64'd1);
    chk("drop_ready", 64'(s_tready), 64'd1);
    mk_frame(60, 16'h0800, 8'd17);
    expect_pkt();
    send(1);
    drain();
    mk_frame(150, 16'h0800, 8'd17);
    send(2);
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("abort_s_tready", 64'(s_tready), 64'd1);
    chk("abort_drop_count", 64'(drop_count), 64'd0);
    chk("abort_m_tvalid", 64'(m_tvalid), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_output", 64'(m_tvalid), 64'd0);
    mk_frame(130, 16'h0800, 8'd17);
    expect_pkt();
    send(3);
    drain();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
